mapping_group_accum_ctrl: RTL and testbench
===========================================

# mapping_group_accum_ctrl

Sequencer and accumulator on the consuming side of a mapping group. For one operation it steps the mapping group through all four count-shift slices (`shift_count` 0..3) and drives the buffer write/read strobes for each slice. It samples the 20-bit weighted partial sum returned per slice and accumulates it into a single result, which is delivered over a valid/ready handshake. It sits between the array-level MAC controller and one mapping group instance.

## Interface
Parameters:
- `ACC_W`, default 32: accumulator and result width; legal range 20..32.
- `SETTLE_CYC`, default 2: idle cycles between the last write strobe and the read strobe of a slice; legal range 0..15.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  start one operation; accepted only in IDLE.
- `mode_i`  in  1  operation mode; latched at start.
- `abort_i`  in  1  synchronous abort of an operation in progress.
- `busy_o`  out  1  high in every state except IDLE.
- `mode_o`  out  1  latched mode, driven to the mapping group.
- `buf_write_en_1_o`  out  1  mapping-group write strobe, phase 1.
- `buf_write_en_2_o`  out  1  mapping-group write strobe, phase 2.
- `buf_read_en_o`  out  1  mapping-group read strobe.
- `shift_count_o`  out  2  current slice index.
- `group_data_i`  in  32  mapping group output; only bits [19:0] are used.
- `result_o`  out  ACC_W  accumulated result.
- `result_valid_o`  out  1  result available.
- `result_ready_i`  in  1  downstream accepts the result.
- `sat_o`  out  1  sticky saturation flag for the current result.

## Operation
- States: IDLE, WR1, WR2, WAIT, RD, ACC, DONE.
- IDLE, `start_i`=1:
  - latch `mode_i` into `mode_o`
  - clear the accumulator, `sat_o` and the slice counter
  - go to WR1
- WR1: `buf_write_en_1_o`=1 for exactly one cycle. Next state is WR2 if the latched mode=1. If mode=0, next state is WAIT, or RD when `SETTLE_CYC`=0.
- WR2: `buf_write_en_2_o`=1 for one cycle, then WAIT (or RD when `SETTLE_CYC`=0).
- WAIT: held for exactly `SETTLE_CYC` cycles, then RD.
- RD: `buf_read_en_o`=1 for one cycle, then ACC.
- ACC:
  - acc <= acc + zero-extended `group_data_i[19:0]`
  - if slice==3, go to DONE; otherwise increment the slice counter and go to WR1
- DONE: `result_valid_o`=1 and `result_o`=acc. Both are held stable until `result_ready_i`=1 is seen on a rising edge, then go to IDLE.
- `shift_count_o` equals the slice counter. It is stable through every state of a slice and reads 0 in IDLE.
- At most one strobe output is high in any cycle.
- `start_i` is ignored in every state except IDLE, including DONE.
- `abort_i`=1 in any non-IDLE state forces IDLE on the next edge:
  - accumulator and slice counter cleared
  - no `result_valid_o` pulse
  - `abort_i` takes priority over the DONE handshake
- Sum width is ACC_W+1 bits. Without the macro the result wraps modulo 2^ACC_W.

## Timing
- Reset values: state IDLE; all strobes 0; `busy_o`=0; `mode_o`=0; `shift_count_o`=0; `result_o`=0; `result_valid_o`=0; `sat_o`=0.
- All outputs are registered or decoded from the state register. No combinational path exists from any input to any output.
- `group_data_i` is sampled in ACC, i.e. the cycle after the `buf_read_en_o` cycle. The mapping group updates its output at the read edge.
- Cycles per slice: 4+`SETTLE_CYC` in mode 1, 3+`SETTLE_CYC` in mode 0.
- `start_i` accepted at edge T gives WR1 in cycle T+1. With defaults, mode 1: `result_valid_o` first goes high at T+25.
- `busy_o` rises the cycle after start is accepted and falls the cycle after the handshake completes.
- Asserting `rst_i` mid-operation returns all outputs to their reset values immediately.

## Configuration
- `MAPPING_ACC_SAT_EN` defined:
  - on carry out of ACC_W bits, acc <= 2^ACC_W−1 and `sat_o` <= 1
  - `sat_o` stays set until the next accepted start or an abort
- `MAPPING_ACC_SAT_EN` undefined: the sum wraps and `sat_o` is tied to 0.

## Test plan
- Defaults, mode 1, `group_data_i`=0x100 every slice, ready held high: expect `result_o`=0x400 and valid at T+25. Per slice, `shift_count_o` steps 0,1,2,3 and the strobe order is wr1, wr2, (2 idle), rd.
- Mode 0, per-slice data 1,2,3,4: `buf_write_en_2_o` never asserts, `result_o`=10, valid at T+21.
- Backpressure: `result_ready_i` low for 5 cycles in DONE. `result_o` and `result_valid_o` stay stable, and `start_i` pulses in DONE are ignored. `busy_o` falls one cycle after ready goes high.
- Abort asserted during WAIT of slice 2: IDLE next cycle, no valid pulse. A new start with data 5 per slice yields 20.
- ACC_W=20, data 0xFFFFF per slice: with the macro, `result_o`=0xFFFFF and `sat_o`=1; without it, `result_o`=0xFFFFC and `sat_o`=0.
- Async reset pulse mid-RD: all outputs reach reset values before the next edge, and a new operation then completes normally.

Source files
------------

// File: rtl/mapping_group_accum_ctrl.sv
// mapping_group_accum_ctrl: steps a mapping group through four shift slices and accumulates its partial sums.
// Optional MAPPING_ACC_SAT_EN saturates the accumulator on carry-out and raises a sticky sat_o.
module mapping_group_accum_ctrl #(
  parameter int ACC_W = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             mode_o,
  output logic             buf_write_en_1_o,
  output logic             buf_write_en_2_o,
  output logic             buf_read_en_o,
  output logic [1:0]       shift_count_o,
  input  logic [31:0]      group_data_i,
  output logic [ACC_W-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             sat_o
);
  typedef enum logic [2:0] {S_IDLE, S_WR1, S_WR2, S_WAIT, S_RD, S_ACC, S_DONE} state_t;
  state_t           state_q, state_d, after_wr;
  logic             mode_q, mode_d, sat_q, sat_d;
  logic [1:0]       slice_q, slice_d;
  logic [3:0]       wait_q, wait_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic             unused_bits;
  assign sum = {1'b0, acc_q} + {{(ACC_W - 19){1'b0}}, group_data_i[19:0]};
  assign unused_bits = ^{group_data_i[31:20], sum[ACC_W]};
  assign after_wr = (SETTLE_CYC == 0) ? S_RD : S_WAIT;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    sat_d = sat_q;
    slice_d = slice_q;
    wait_d = wait_q;
    acc_d = acc_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_WR1;
        mode_d = mode_i;
        acc_d = '0;
        sat_d = 1'b0;
        slice_d = 2'd0;
      end
      S_WR1: begin
        state_d = mode_q ? S_WR2 : after_wr;
        wait_d = 4'(SETTLE_CYC - 1);
      end
      S_WR2: begin
        state_d = after_wr;
        wait_d = 4'(SETTLE_CYC - 1);
      end
      S_WAIT: begin
        state_d = (wait_q == 4'd0) ? S_RD : S_WAIT;
        wait_d = wait_q - 4'd1;
      end
      S_RD: state_d = S_ACC;
      S_ACC: begin
`ifdef MAPPING_ACC_SAT_EN
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat_d = sat_q | sum[ACC_W];
`else
        acc_d = sum[ACC_W-1:0];
`endif
        state_d = (slice_q == 2'd3) ? S_DONE : S_WR1;
        slice_d = (slice_q == 2'd3) ? slice_q : slice_q + 2'd1;
      end
      S_DONE: if (result_ready_i) begin
        state_d = S_IDLE;
        slice_d = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
    // abort outranks everything, including the result handshake
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      acc_d = '0;
      sat_d = 1'b0;
      slice_d = 2'd0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q <= 1'b0;
      sat_q <= 1'b0;
      slice_q <= 2'd0;
      wait_q <= 4'd0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      sat_q <= sat_d;
      slice_q <= slice_d;
      wait_q <= wait_d;
      acc_q <= acc_d;
    end
  end
  assign busy_o = state_q != S_IDLE;
  assign mode_o = mode_q;
  assign buf_write_en_1_o = state_q == S_WR1;
  assign buf_write_en_2_o = state_q == S_WR2;
  assign buf_read_en_o = state_q == S_RD;
  assign shift_count_o = slice_q;
  assign result_o = acc_q;
  assign result_valid_o = state_q == S_DONE;
  assign sat_o = sat_q;
endmodule

// File: tb/tb_mapping_group_accum_ctrl.sv
// tb_mapping_group_accum_ctrl: drives a 32-bit and a 20-bit accumulator instance in lockstep
// and checks them against a per-cycle strobe trace and an arithmetic sum model.
module tb_mapping_group_accum_ctrl;
  localparam int SETTLE = 2;
  logic clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, mode_i = 1'b0, abort_i = 1'b0, result_ready_i = 1'b0;
  logic [31:0] group_data_i = 32'h0;
  logic busy_a, mode_a, w1_a, w2_a, rd_a, valid_a, sat_a;
  logic busy_b, mode_b, w1_b, w2_b, rd_b, valid_b, sat_b;
  logic [1:0] sc_a, sc_b;
  logic [31:0] res_a;
  logic [19:0] res_b;
  logic [7:0] ctl_a, ctl_b;
  logic [19:0] sd [4];
  int n_cmp = 0, n_err = 0, op_id = 0;
  always #5 clk_i = ~clk_i;
  assign ctl_a = {busy_a, mode_a, w1_a, w2_a, rd_a, sc_a, valid_a};
  assign ctl_b = {busy_b, mode_b, w1_b, w2_b, rd_b, sc_b, valid_b};
  mapping_group_accum_ctrl #(.ACC_W(32), .SETTLE_CYC(SETTLE)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .busy_o(busy_a), .mode_o(mode_a), .buf_write_en_1_o(w1_a), .buf_write_en_2_o(w2_a),
    .buf_read_en_o(rd_a), .shift_count_o(sc_a), .group_data_i(group_data_i), .result_o(res_a),
    .result_valid_o(valid_a), .result_ready_i(result_ready_i), .sat_o(sat_a));
  mapping_group_accum_ctrl #(.ACC_W(20), .SETTLE_CYC(SETTLE)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .busy_o(busy_b), .mode_o(mode_b), .buf_write_en_1_o(w1_b), .buf_write_en_2_o(w2_b),
    .buf_read_en_o(rd_b), .shift_count_o(sc_b), .group_data_i(group_data_i), .result_o(res_b),
    .result_valid_o(valid_b), .result_ready_i(result_ready_i), .sat_o(sat_b));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {48'h0, ctl_a, ctl_b}, 64'h0);
    chk({tag, "_res"}, {10'h0, res_a, res_b, sat_a, sat_b}, 64'h0);
  endtask
  task automatic set_data(input logic [19:0] d0, d1, d2, d3);
    sd[0] = d0; sd[1] = d1; sd[2] = d2; sd[3] = d3;
  endtask
  // cut: 0 none, 1 abort in first settle cycle of cut_slice, 2 async reset in read cycle of cut_slice
  task automatic run_op(input logic m, input int hold, input int cut, input int cut_slice);
    int kind[$];
    int sl[$];
    longint total = 0;
    logic [31:0] e32, r;
    logic [19:0] e20;
    logic es;
    logic [7:0] ex;
    op_id++;
    for (int s = 0; s < 4; s++) begin
      kind.push_back(1); sl.push_back(s);
      if (m) begin kind.push_back(2); sl.push_back(s); end
      for (int k = 0; k < SETTLE; k++) begin kind.push_back(0); sl.push_back(s); end
      kind.push_back(3); sl.push_back(s);
      kind.push_back(4); sl.push_back(s);
      total += longint'(sd[s]);
    end
    result_ready_i = (hold == 0);
    @(negedge clk_i);
    start_i = 1'b1;
    mode_i = m;
    @(negedge clk_i);
    start_i = 1'b0;
    mode_i = ~m;
    for (int i = 0; i < kind.size(); i++) begin
      if (i > 0) @(negedge clk_i);
      ex = {1'b1, m, kind[i] == 1, kind[i] == 2, kind[i] == 3, 2'(sl[i]), 1'b0};
      chk($sformatf("ctl_op%0d_c%0d", op_id, i), {48'h0, ctl_a, ctl_b}, {48'h0, ex, ex});
      r = $urandom;
      group_data_i = (kind[i] == 4) ? {r[31:20], sd[sl[i]]} : r;
      if (cut == 1 && kind[i] == 0 && sl[i] == cut_slice) begin
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        ex = {1'b0, m, 6'h0};
        chk($sformatf("abort_ctl_op%0d", op_id), {48'h0, ctl_a, ctl_b}, {48'h0, ex, ex});
        chk($sformatf("abort_res_op%0d", op_id), {10'h0, res_a, res_b, sat_a, sat_b}, 64'h0);
        @(negedge clk_i);
        chk($sformatf("abort_quiet_op%0d", op_id), {62'h0, valid_a, valid_b}, 64'h0);
        return;
      end
      if (cut == 2 && kind[i] == 3 && sl[i] == cut_slice) begin
        rst_i = 1'b1;
        #1;
        chk_reset($sformatf("midrst_op%0d", op_id));
        #1 rst_i = 1'b0;
        return;
      end
    end
    @(negedge clk_i);
    e32 = total[31:0];
`ifdef MAPPING_ACC_SAT_EN
    es = total > 64'hFFFFF;
    e20 = es ? 20'hFFFFF : total[19:0];
`else
    es = 1'b0;
    e20 = total[19:0];
`endif
    ex = {1'b1, m, 3'b000, 2'b00, 1'b1};
    chk($sformatf("done_ctl_op%0d", op_id), {52'h0, ctl_a[7:3], ctl_a[0], ctl_b[7:3], ctl_b[0]},
        {52'h0, ex[7:3], ex[0], ex[7:3], ex[0]});
    chk($sformatf("done_res_op%0d", op_id), {10'h0, res_a, res_b, sat_a, sat_b}, {10'h0, e32, e20, 1'b0, es});
    for (int h = 0; h < hold; h++) begin
      start_i = ~h[0];
      @(negedge clk_i);
      chk($sformatf("hold_op%0d_h%0d", op_id, h), {18'h0, busy_a, valid_a, busy_b, valid_b, res_a, res_b, sat_a, sat_b},
          {18'h0, 4'hF, e32, e20, 1'b0, es});
    end
    start_i = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    ex = {1'b0, m, 6'h0};
    chk($sformatf("idle_op%0d", op_id), {48'h0, ctl_a, ctl_b}, {48'h0, ex, ex});
    result_ready_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    #2 rst_i = 1'b1;
    #2 chk_reset("por");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset("por_idle");
    set_data(20'h100, 20'h100, 20'h100, 20'h100);
    run_op(1'b1, 0, 0, 0);
    set_data(20'd1, 20'd2, 20'd3, 20'd4);
    run_op(1'b0, 0, 0, 0);
    set_data(20'(($urandom)), 20'(($urandom)), 20'(($urandom)), 20'(($urandom)));
    run_op(1'b1, 5, 0, 0);
    set_data(20'h3, 20'h3, 20'h3, 20'h3);
    run_op(1'b1, 0, 1, 2);
    set_data(20'd5, 20'd5, 20'd5, 20'd5);
    run_op(1'b1, 0, 0, 0);
    set_data(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    run_op(1'b0, 2, 0, 0);
    set_data(20'h7, 20'h7, 20'h7, 20'h7);
    run_op(1'b1, 0, 2, 1);
    @(negedge clk_i);
    chk_reset("post_rst");
    set_data(20'h11, 20'h22, 20'h33, 20'h44);
    run_op(1'b1, 1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      for (int s = 0; s < 4; s++) sd[s] = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
      run_op(1'($urandom), int'($urandom_range(0, 4)), 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
